term_ctrl: RTL

Terminal control stage directly upstream of the character-buffer fill writer. It consumes received bytes (UART RX byte stream) and turns printable characters and control codes into fill commands on the writer's wr_* interface (wr_start/wr_begin/wr_end/wr_data/wr_offset). It tracks the cursor, auto-wraps, and scrolls by moving wr_offset. It sits between the UART receiver and the text-buffer writer in top.

---
 rtl/term_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/term_ctrl.sv
// Terminal control stage: turns received bytes into fill commands for the
// character-buffer writer, tracking the cursor and scrolling via wr_offset.
module term_ctrl #(
  parameter int COLS   = 80,
  parameter int ROWS   = 30,
  parameter int ADDR_W = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rx_valid,
  input  logic [7:0]              rx_data,
  output logic                    rx_ready,
  output logic                    wr_start,
  output logic [ADDR_W-1:0]       wr_begin,
  output logic [ADDR_W-1:0]       wr_end,
  output logic [7:0]              wr_data,
  output logic [ADDR_W-1:0]       wr_offset,
  input  logic                    wr_busy,
  output logic [$clog2(COLS)-1:0] cursor_x,
  output logic [$clog2(ROWS)-1:0] cursor_y
);
  localparam int XW = $clog2(COLS);
  localparam int YW = $clog2(ROWS);
  localparam logic [ADDR_W-1:0] CELLS     = ADDR_W'(COLS * ROWS);
  localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'((ROWS - 1) * COLS);
  localparam logic [XW-1:0]     X_MAX     = XW'(COLS - 1);
  localparam logic [YW-1:0]     Y_MAX     = YW'(ROWS - 1);
  localparam logic [7:0]        SPACE     = 8'h20;

  typedef enum logic [2:0] {INIT, IDLE, ISSUE, WAIT1, WAIT, SCROLL} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] begin_reg, begin_next;
  logic [ADDR_W-1:0] end_reg, end_next;
  logic [7:0]        data_reg, data_next;
  logic [ADDR_W-1:0] offset_reg, offset_next;
  logic [XW-1:0]     x_reg, x_next;
  logic [YW-1:0]     y_reg, y_next;
  logic              adv_reg, adv_next;   // cursor advance deferred until the fill completes
  logic [ADDR_W-1:0] cell_idx;

  assign cell_idx = ADDR_W'(y_reg) * COLS_A + ADDR_W'(x_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= INIT;
      begin_reg  <= '0;
      end_reg    <= '0;
      data_reg   <= SPACE;
      offset_reg <= '0;
      x_reg      <= '0;
      y_reg      <= '0;
      adv_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      begin_reg  <= begin_next;
      end_reg    <= end_next;
      data_reg   <= data_next;
      offset_reg <= offset_next;
      x_reg      <= x_next;
      y_reg      <= y_next;
      adv_reg    <= adv_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    begin_next  = begin_reg;
    end_next    = end_reg;
    data_next   = data_reg;
    offset_next = offset_reg;
    x_next      = x_reg;
    y_next      = y_reg;
    adv_next    = adv_reg;
    case (state_reg)
      INIT: begin
        begin_next = '0;
        end_next   = CELLS;
        data_next  = SPACE;
        adv_next   = 1'b0;
        state_next = ISSUE;
      end
      IDLE: begin
        if (rx_valid) begin
          if (rx_data >= 8'h20 && rx_data <= 8'h7E) begin
            begin_next = cell_idx;
            end_next   = cell_idx + 1'b1;
            data_next  = rx_data;
            adv_next   = 1'b1;
            state_next = ISSUE;
          end else begin
            case (rx_data)
              8'h0D: x_next = '0;
              8'h0A: begin
                if (y_reg != Y_MAX) y_next = y_reg + 1'b1;
                else state_next = SCROLL;
              end
              8'h08: if (x_reg != '0) x_next = x_reg - 1'b1;
              8'h0C: begin
                offset_next = '0;
                x_next      = '0;
                y_next      = '0;
                state_next  = INIT;
              end
              default: ;
            endcase
          end
        end
      end
      ISSUE: state_next = WAIT1;
      // writer raises busy one cycle after wr_start, so it cannot be trusted yet
      WAIT1: state_next = WAIT;
      WAIT: begin
        if (!wr_busy) begin
          state_next = IDLE;
          adv_next   = 1'b0;
          if (adv_reg) begin
            if (x_reg == X_MAX) begin
              x_next = '0;
              if (y_reg == Y_MAX) state_next = SCROLL;
              else y_next = y_reg + 1'b1;
            end else begin
              x_next = x_reg + 1'b1;
            end
          end
        end
      end
      SCROLL: begin
        // compare before adding so the offset never exceeds the screen size
        if (offset_reg >= LAST_ROW) offset_next = offset_reg - LAST_ROW;
        else offset_next = offset_reg + COLS_A;
        begin_next = LAST_ROW;
        end_next   = CELLS;
        data_next  = SPACE;
        adv_next   = 1'b0;
        state_next = ISSUE;
      end
      default: state_next = INIT;
    endcase
  end

  assign rx_ready  = (state_reg == IDLE);
  assign wr_start  = (state_reg == ISSUE);
  assign wr_begin  = begin_reg;
  assign wr_end    = end_reg;
  assign wr_data   = data_reg;
  assign wr_offset = offset_reg;
  assign cursor_x  = x_reg;
  assign cursor_y  = y_reg;
endmodule
